// File: rtl/spi_slave_regs_if.sv
// spi_slave_regs_if: bundles the SPI pins and the parallel register-side
// signals of spi_slave_regs. The slave modport is the device view; the master
// modport is the view of whatever drives the SPI pins and observes the bank.
interface spi_slave_regs_if;
  logic        spiClk_i;
  logic        spiMosi_i;
  logic        spiMiso_o;
  logic [7:0]  status_i;
  logic [63:0] regs_o;
  logic        wr_stb_o;
  logic [2:0]  wr_adr_o;
  logic [7:0]  wr_dat_o;

  modport slave (
    input  spiClk_i, spiMosi_i, status_i,
    output spiMiso_o, regs_o, wr_stb_o, wr_adr_o, wr_dat_o
  );

  modport master (
    output spiClk_i, spiMosi_i, status_i,
    input  spiMiso_o, regs_o, wr_stb_o, wr_adr_o, wr_dat_o
  );
endinterface

// File: rtl/spi_slave_regs.sv
// spi_slave_regs: mode-0 SPI device with a bank of eight 8-bit registers
// (0..6 writable, 7 = read-only status). SCK/MOSI are oversampled in the
// clk_i domain. A frame is one command byte (bit7 = write, bits[2:0] = index)
// followed by data bytes; a frame ends when SCK stays quiet for IDLE_CYCLES.
// Optional feature: define SPI_SLAVE_AUTOINC_EN to advance the register index
// after every data byte; otherwise the index stays fixed for the frame.
module spi_slave_regs #(
  parameter int unsigned IDLE_CYCLES = 64
) (
  input logic            clk_i,
  input logic            rst_i,
  spi_slave_regs_if.slave bus
);

  typedef enum logic [1:0] {CMD, WRITE, READ} state_e;

  localparam logic [15:0] IDLE_LIMIT = 16'(IDLE_CYCLES);

  logic [2:0]       sckSync_q;
  logic [1:0]       mosiSync_q;
  logic             sckRise;
  logic             sckFall;

  state_e           state_q, state_d;
  logic [2:0]       bitCnt_q, bitCnt_d;
  logic [7:0]       shiftIn_q, shiftIn_d;
  logic [7:0]       shiftOut_q, shiftOut_d;
  logic [2:0]       index_q, index_d;
  logic             loadPend_q, loadPend_d;
  logic [15:0]      idleCnt_q, idleCnt_d;
  logic             miso_q, miso_d;
  logic             wrStb_q, wrStb_d;
  logic [2:0]       wrAdr_q, wrAdr_d;
  logic [7:0]       wrDat_q, wrDat_d;
  logic [6:0][7:0]  regs_q, regs_d;

  logic [7:0]       rxByte;
  logic [7:0]       readByte;

  // Two-flop synchronizers on both pins plus a third SCK flop for edge detect
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sckSync_q  <= '0;
      mosiSync_q <= '0;
    end else begin
      sckSync_q  <= {sckSync_q[1:0], bus.spiClk_i};
      mosiSync_q <= {mosiSync_q[0], bus.spiMosi_i};
    end
  end

  assign sckRise = sckSync_q[1] & ~sckSync_q[2];
  assign sckFall = ~sckSync_q[1] & sckSync_q[2];
  assign rxByte  = {shiftIn_q[6:0], mosiSync_q[1]};

  // Register selected by the current index; index 7 reads the live status input
  always_comb begin
    readByte = bus.status_i;
    for (int n = 0; n < 7; n++) begin
      if (index_q == 3'(n)) readByte = regs_q[n];
    end
  end

  // Frame state, counters, shifters and the register bank
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= CMD;
      bitCnt_q   <= '0;
      shiftIn_q  <= '0;
      shiftOut_q <= '0;
      index_q    <= '0;
      loadPend_q <= 1'b0;
      idleCnt_q  <= '0;
      miso_q     <= 1'b0;
      wrStb_q    <= 1'b0;
      wrAdr_q    <= '0;
      wrDat_q    <= '0;
      regs_q     <= '0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      shiftIn_q  <= shiftIn_d;
      shiftOut_q <= shiftOut_d;
      index_q    <= index_d;
      loadPend_q <= loadPend_d;
      idleCnt_q  <= idleCnt_d;
      miso_q     <= miso_d;
      wrStb_q    <= wrStb_d;
      wrAdr_q    <= wrAdr_d;
      wrDat_q    <= wrDat_d;
      regs_q     <= regs_d;
    end
  end

  // Next-state: byte assembly on SCK rise, MISO shifting on SCK fall, idle timeout
  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    shiftIn_d  = shiftIn_q;
    shiftOut_d = shiftOut_q;
    index_d    = index_q;
    loadPend_d = loadPend_q;
    idleCnt_d  = idleCnt_q;
    miso_d     = miso_q;
    wrStb_d    = 1'b0;
    wrAdr_d    = wrAdr_q;
    wrDat_d    = wrDat_q;
    regs_d     = regs_q;

    if (sckRise || sckFall) begin
      idleCnt_d = '0;
      if (sckRise) begin
        shiftIn_d = rxByte;
        bitCnt_d  = bitCnt_q + 3'd1;
        if (bitCnt_q == 3'd7) begin
          case (state_q)
            CMD: begin
              index_d = rxByte[2:0];
              if (rxByte[7]) begin
                state_d = WRITE;
              end else begin
                state_d    = READ;
                loadPend_d = 1'b1;
              end
            end
            WRITE: begin
              if (index_q != 3'd7) begin
                for (int n = 0; n < 7; n++) begin
                  if (index_q == 3'(n)) regs_d[n] = rxByte;
                end
                wrStb_d = 1'b1;
                wrAdr_d = index_q;
                wrDat_d = rxByte;
              end
`ifdef SPI_SLAVE_AUTOINC_EN
              index_d = index_q + 3'd1;
`endif
            end
            READ: begin
              loadPend_d = 1'b1;
            end
            default: begin
              state_d = CMD;
            end
          endcase
        end
      end
      if (sckFall && (state_q == READ)) begin
        if (loadPend_q) begin
          shiftOut_d = readByte;
          miso_d     = readByte[7];
          loadPend_d = 1'b0;
`ifdef SPI_SLAVE_AUTOINC_EN
          index_d    = index_q + 3'd1;
`endif
        end else begin
          shiftOut_d = {shiftOut_q[6:0], 1'b0};
          miso_d     = shiftOut_q[6];
        end
      end
    end else if (idleCnt_q == IDLE_LIMIT) begin
      state_d    = CMD;
      bitCnt_d   = '0;
      miso_d     = 1'b0;
      loadPend_d = 1'b0;
    end else begin
      idleCnt_d = idleCnt_q + 16'd1;
    end
  end

  assign bus.spiMiso_o = miso_q;
  assign bus.wr_stb_o  = wrStb_q;
  assign bus.wr_adr_o  = wrAdr_q;
  assign bus.wr_dat_o  = wrDat_q;
  assign bus.regs_o    = {bus.status_i, regs_q};

endmodule

// File: tb/tb_spi_slave_regs.sv
// tb_spi_slave_regs: drives SPI frames into spi_slave_regs as a mode-0 master.
// Expected write strobes and read bytes are queued when a frame is issued;
// independent monitors pop and compare them when the DUT produces them.
module tb_spi_slave_regs;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  spi_slave_regs_if bus();

  spi_slave_regs #(.IDLE_CYCLES(64)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // Free-running system clock, 10 time units per period
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  logic [10:0] wrExpQ[$];
  logic [7:0]  rdExpQ[$];
  logic [7:0]  modelRegs[7];
  logic        captureEn = 1'b0;
  logic        autoInc;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Write-strobe monitor: every strobe must match the oldest queued write
  initial begin
    logic [10:0] exp;
    forever begin
      @(negedge clk_i);
      if (bus.wr_stb_o === 1'b1) begin
        if (wrExpQ.size() == 0) begin
          checkOutput("unexpectedStrobe", {53'd0, bus.wr_adr_o, bus.wr_dat_o}, 64'd0);
        end else begin
          exp = wrExpQ.pop_front();
          checkOutput("writeStrobe", {53'd0, bus.wr_adr_o, bus.wr_dat_o}, {53'd0, exp});
        end
      end
    end
  end

  // MISO monitor: deserializes read data bytes sampled on SCK rise
  initial begin
    logic [7:0] rdShift;
    int         rdBits;
    rdShift = '0;
    rdBits  = 0;
    forever begin
      @(posedge bus.spiClk_i);
      if (captureEn) begin
        rdShift = {rdShift[6:0], bus.spiMiso_o};
        rdBits++;
        if (rdBits == 8) begin
          rdBits = 0;
          if (rdExpQ.size() == 0) begin
            checkOutput("unexpectedRead", {56'd0, rdShift}, 64'd0);
          end else begin
            checkOutput("readByte", {56'd0, rdShift}, {56'd0, rdExpQ.pop_front()});
          end
        end
      end
    end
  end

  // Bound the whole run in case the DUT or bench stalls
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic sendBits(input logic [7:0] tx, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      bus.spiMosi_i = tx[i];
      repeat (8) @(negedge clk_i);
      bus.spiClk_i = 1'b1;
      repeat (8) @(negedge clk_i);
      bus.spiClk_i = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] cmd, input int nData,
                               input logic [7:0] d0, input logic [7:0] d1,
                               input logic [7:0] d2);
    logic [7:0] data[3];
    logic [2:0] idx;
    data[0] = d0;
    data[1] = d1;
    data[2] = d2;
    idx = cmd[2:0];
    sendBits(cmd, 8);
    for (int k = 0; k < nData; k++) begin
      if (cmd[7]) begin
        if (idx != 3'd7) begin
          wrExpQ.push_back({idx, data[k]});
          modelRegs[idx] = data[k];
        end
      end else begin
        if (idx == 3'd7) rdExpQ.push_back(bus.status_i);
        else             rdExpQ.push_back(modelRegs[idx]);
        captureEn = 1'b1;
      end
      if (autoInc) idx = idx + 3'd1;
      sendBits(data[k], 8);
      captureEn = 1'b0;
    end
    repeat (80) @(negedge clk_i);
    checkOutput("writesDrained", 64'(wrExpQ.size()), 64'd0);
  endtask

  initial begin
`ifdef SPI_SLAVE_AUTOINC_EN
    autoInc = 1'b1;
`else
    autoInc = 1'b0;
`endif
    for (int i = 0; i < 7; i++) modelRegs[i] = 8'h00;
    bus.spiClk_i  = 1'b0;
    bus.spiMosi_i = 1'b0;
    bus.status_i  = 8'h00;

    #1 rst_i = 1'b0;
    repeat (4) @(negedge clk_i);
    checkOutput("rstMiso", {63'd0, bus.spiMiso_o}, 64'd0);
    checkOutput("rstStb",  {63'd0, bus.wr_stb_o},  64'd0);
    checkOutput("rstAdr",  {61'd0, bus.wr_adr_o},  64'd0);
    checkOutput("rstDat",  {56'd0, bus.wr_dat_o},  64'd0);
    checkOutput("rstRegs", bus.regs_o, 64'd0);
    rst_i = 1'b1;
    repeat (4) @(negedge clk_i);

    $display("[TB] read reg3 after reset");
    applyStimulus(8'h03, 1, 8'h00, 8'h00, 8'h00);

    $display("[TB] write 0x82 A5 3C");
    applyStimulus(8'h82, 2, 8'hA5, 8'h3C, 8'h00);
    checkOutput("reg2", {56'd0, bus.regs_o[23:16]}, autoInc ? 64'hA5 : 64'h3C);
    checkOutput("reg3", {56'd0, bus.regs_o[31:24]}, autoInc ? 64'h3C : 64'h00);

    $display("[TB] write 0x86 11 22 33 across read-only index");
    applyStimulus(8'h86, 3, 8'h11, 8'h22, 8'h33);
    checkOutput("reg6", {56'd0, bus.regs_o[55:48]}, autoInc ? 64'h11 : 64'h33);
    checkOutput("reg0", {56'd0, bus.regs_o[7:0]},   autoInc ? 64'h33 : 64'h00);

    $display("[TB] read status index 7");
    bus.status_i = 8'h5A;
    repeat (2) @(negedge clk_i);
    checkOutput("statusMirror", {56'd0, bus.regs_o[63:56]}, 64'h5A);
    applyStimulus(8'h07, 2, 8'h00, 8'h00, 8'h00);

    $display("[TB] partial byte then write 0x81 FF");
    sendBits(8'hA8, 5);
    repeat (80) @(negedge clk_i);
    applyStimulus(8'h81, 1, 8'hFF, 8'h00, 8'h00);
    checkOutput("reg1", {56'd0, bus.regs_o[15:8]}, 64'hFF);
    checkOutput("lastAdr", {61'd0, bus.wr_adr_o}, 64'd1);
    checkOutput("lastDat", {56'd0, bus.wr_dat_o}, 64'hFF);

    $display("[TB] reset in the middle of a write data byte");
    sendBits(8'h84, 8);
    sendBits(8'h77, 4);
    bus.spiClk_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    bus.spiClk_i  = 1'b0;
    bus.spiMosi_i = 1'b0;
    checkOutput("midRstMiso", {63'd0, bus.spiMiso_o}, 64'd0);
    checkOutput("midRstStb",  {63'd0, bus.wr_stb_o},  64'd0);
    checkOutput("midRstAdr",  {61'd0, bus.wr_adr_o},  64'd0);
    checkOutput("midRstDat",  {56'd0, bus.wr_dat_o},  64'd0);
    checkOutput("midRstRegs", {8'd0, bus.regs_o[55:0]}, 64'd0);
    for (int i = 0; i < 7; i++) modelRegs[i] = 8'h00;
    rst_i = 1'b1;
    repeat (4) @(negedge clk_i);

    $display("[TB] frames after reset");
    applyStimulus(8'h80, 1, 8'h42, 8'h00, 8'h00);
    checkOutput("reg0AfterRst", {56'd0, bus.regs_o[7:0]}, 64'h42);
    applyStimulus(8'h00, 1, 8'h00, 8'h00, 8'h00);
    applyStimulus(8'h01, 1, 8'h00, 8'h00, 8'h00);

    checkOutput("readsDrained", 64'(rdExpQ.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
